// File: rtl/life_cell_rule.sv
// life_cell_rule: one registered Game-of-Life cell.
// Counts live neighbours, applies birth/survive rule masks on each step,
// supports seed loading, tracks stability and (optionally) the cell's age.
// Optional feature macro: LIFE_CELL_AGE_EN enables the saturating age
// counter; without it the age output is tied to zero.
module life_cell_rule #(
  parameter int N_NBR = 8,
  parameter logic [N_NBR:0] BIRTH_MASK = 9'b000001000,
  parameter logic [N_NBR:0] SURVIVE_MASK = 9'b000001100,
  parameter int AGE_W = 8,
  parameter int STABLE_GENS = 4,
  localparam int CNT_W = $clog2(N_NBR + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_NBR-1:0] nbr,
  input  logic             step,
  input  logic             load,
  input  logic             seed,
  output logic             alive,
  output logic [CNT_W-1:0] count,
  output logic             none_alive,
  output logic             changed,
  output logic             stable,
  output logic [AGE_W-1:0] age
);

  // Stability counter only needs to reach STABLE_GENS, where it saturates.
  localparam int SC_W = $clog2(STABLE_GENS + 1);
  localparam logic [SC_W-1:0] STAB_MAX = SC_W'(STABLE_GENS);

  logic [CNT_W-1:0] cnt_p0;
  logic             nxt_p0;
  logic [SC_W-1:0]  stab_upd_p0;
  logic [SC_W-1:0]  stab_cnt_p1;

  // Population count of the neighbour inputs, zero-extended to CNT_W.
  always_comb begin
    cnt_p0 = '0;
    for (int i = 0; i < N_NBR; i++) begin
      cnt_p0 = cnt_p0 + CNT_W'(nbr[i]);
    end
  end

  assign count      = cnt_p0;
  assign none_alive = (cnt_p0 == '0);

  // Rule lookup: a live cell consults the survive mask, a dead one the birth mask.
  always_comb begin
    nxt_p0 = alive ? SURVIVE_MASK[cnt_p0] : BIRTH_MASK[cnt_p0];
  end

  // Unchanged generations extend the run (saturating); any change restarts it.
  always_comb begin
    if (nxt_p0 != alive) begin
      stab_upd_p0 = '0;
    end else if (stab_cnt_p1 == STAB_MAX) begin
      stab_upd_p0 = STAB_MAX;
    end else begin
      stab_upd_p0 = stab_cnt_p1 + SC_W'(1);
    end
  end

  // Cell state, change pulse and stability tracking: reset > load > step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      alive       <= 1'b0;
      changed     <= 1'b0;
      stable      <= 1'b0;
      stab_cnt_p1 <= '0;
    end else if (load) begin
      alive       <= seed;
      changed     <= seed ^ alive;
      stable      <= 1'b0;
      stab_cnt_p1 <= '0;
    end else if (step) begin
      alive       <= nxt_p0;
      changed     <= nxt_p0 ^ alive;
      stab_cnt_p1 <= stab_upd_p0;
      stable      <= (stab_upd_p0 >= STAB_MAX);
    end else begin
      changed     <= 1'b0;
    end
  end

`ifdef LIFE_CELL_AGE_EN
  logic [AGE_W-1:0] age_p1;

  // Age counts consecutive survivals, saturating; birth, death or staying dead clears it.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      age_p1 <= '0;
    end else if (step) begin
      if (alive && nxt_p0) begin
        age_p1 <= (age_p1 == '1) ? age_p1 : age_p1 + AGE_W'(1);
      end else begin
        age_p1 <= '0;
      end
    end
  end

  assign age = age_p1;
`else
  assign age = '0;
`endif

endmodule

// File: tb/tb_life_cell_rule.sv
// Testbench for life_cell_rule: directed scenarios plus randomized stimulus,
// checked every cycle against a behavioural B3/S23 cell model.
module tb_life_cell_rule;

  localparam int SG = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] nbr = 8'h00;
  logic       step = 1'b0;
  logic       load = 1'b0;
  logic       seed = 1'b0;

  logic       alive, none_alive, changed, stable;
  logic [3:0] count;
  logic [7:0] age;

  logic       s_alive, s_none, s_changed, s_stable;
  logic [3:0] s_count;
  logic [1:0] s_age;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_valid = 0;
  bit m_alive = 0;
  bit m_changed = 0;
  int m_run = 0;   // consecutive unchanged steps since reset/load/change
  int m_age = 0;   // consecutive survivals, unbounded

  always #5 clk = ~clk;

  life_cell_rule u_dut (
    .clk(clk), .reset(reset), .nbr(nbr), .step(step), .load(load), .seed(seed),
    .alive(alive), .count(count), .none_alive(none_alive), .changed(changed),
    .stable(stable), .age(age)
  );

  life_cell_rule #(.AGE_W(2)) u_sat (
    .clk(clk), .reset(reset), .nbr(nbr), .step(step), .load(load), .seed(seed),
    .alive(s_alive), .count(s_count), .none_alive(s_none), .changed(s_changed),
    .stable(s_stable), .age(s_age)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int exp_age(int n, int w);
`ifdef LIFE_CELL_AGE_EN
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  // Reference model: Conway B3/S23 rule evaluated from the neighbour population.
  always @(posedge clk) begin : model
    int k;
    bit nx;
    k  = $countones(nbr);
    nx = m_alive ? (k == 2 || k == 3) : (k == 3);
    if (reset) begin
      m_valid   <= 1;
      m_alive   <= 0;
      m_changed <= 0;
      m_run     <= 0;
      m_age     <= 0;
    end else if (m_valid) begin
      if (load) begin
        m_changed <= (seed != m_alive);
        m_alive   <= seed;
        m_run     <= 0;
        m_age     <= 0;
      end else if (step) begin
        m_changed <= (nx != m_alive);
        m_run     <= (nx == m_alive) ? m_run + 1 : 0;
        m_age     <= (m_alive && nx) ? m_age + 1 : 0;
        m_alive   <= nx;
      end else begin
        m_changed <= 0;
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    chk("count", 32'(count), 32'($countones(nbr)));
    chk("none_alive", 32'(none_alive), 32'(nbr == 8'h00));
    if (m_valid) begin
      chk("alive", 32'(alive), 32'(m_alive));
      chk("changed", 32'(changed), 32'(m_changed));
      chk("stable", 32'(stable), 32'(m_run >= SG));
      chk("age", 32'(age), 32'(exp_age(m_age, 8)));
      chk("sat_alive", 32'(s_alive), 32'(m_alive));
      chk("sat_age", 32'(s_age), 32'(exp_age(m_age, 2)));
      chk("sat_flags", 32'({s_changed, s_stable, s_none, s_count}),
          32'({m_changed, (m_run >= SG), (nbr == 8'h00), 4'($countones(nbr))}));
    end
  end

  // Drive one cycle of inputs and return just after the sampling edge.
  task automatic tick(input logic r, input logic l, input logic s,
                      input logic st, input logic [7:0] nb);
    reset = r; load = l; seed = s; step = st; nbr = nb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    // Reset dominates load/step
    tick(1, 1, 1, 1, 8'h00);
    tick(1, 1, 1, 1, 8'h00);
    chk("rst_alive", 32'(alive), 0);
    chk("rst_changed", 32'(changed), 0);
    chk("rst_stable", 32'(stable), 0);
    chk("rst_age", 32'(age), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_none", 32'(none_alive), 1);

    // Birth on exactly three neighbours
    tick(0, 0, 0, 0, 8'b00000111);
    chk("birth_count", 32'(count), 3);
    tick(0, 0, 0, 1, 8'b00000111);
    chk("birth_alive", 32'(alive), 1);
    chk("birth_changed", 32'(changed), 1);
    chk("birth_age", 32'(age), 0);
    chk("model_birth", 32'(m_alive), 1);
    tick(0, 0, 0, 0, 8'b00000111);
    chk("birth_idle_changed", 32'(changed), 0);

    // Survive with two neighbours, age grows
    tick(0, 1, 1, 0, 8'b00000011);
    for (int i = 1; i <= 5; i++) begin
      tick(0, 0, 0, 1, 8'b00000011);
      chk("surv_alive", 32'(alive), 1);
      chk("surv_changed", 32'(changed), 0);
      chk("surv_age", 32'(age), 32'(exp_age(i, 8)));
      chk("surv_age_sat", 32'(s_age), 32'(exp_age(i, 2)));
    end
    chk("model_age", 32'(m_age), 5);
`ifdef LIFE_CELL_AGE_EN
    chk("age_lit5", 32'(age), 5);
    chk("age_sat3", 32'(s_age), 3);
`endif

    // Death by overcrowding
    tick(0, 0, 0, 0, 8'hFF);
    chk("death_count", 32'(count), 8);
    tick(0, 0, 0, 1, 8'hFF);
    chk("death_alive", 32'(alive), 0);
    chk("death_changed", 32'(changed), 1);
    chk("death_age", 32'(age), 0);
    tick(0, 0, 0, 1, 8'h00);
    chk("dead_alive", 32'(alive), 0);
    chk("dead_none", 32'(none_alive), 1);

    // Load beats step; reset beats load
    tick(0, 1, 1, 1, 8'h00);
    chk("prio_alive", 32'(alive), 1);
    chk("prio_stable", 32'(stable), 0);
    tick(1, 1, 1, 0, 8'h00);
    chk("prio_rst_alive", 32'(alive), 0);

    // Stability after four unchanged generations
    for (int i = 1; i <= 4; i++) begin
      tick(0, 0, 0, 1, 8'h01);
      chk("stab_step", 32'(stable), (i == 4) ? 1 : 0);
    end
    tick(0, 0, 0, 1, 8'b00000111);
    chk("stab_break_alive", 32'(alive), 1);
    chk("stab_break_stable", 32'(stable), 0);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] nb;
      nb = ($urandom_range(0, 1) == 0) ? 8'($urandom)
                                       : 8'($urandom & $urandom & $urandom);
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom), ($urandom_range(0, 3) != 0), nb);
    end

    tick(0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
